// File: rtl/fifo_pkg.sv
// fifo_pkg: shared types and defaults for the FIFO read-side consumer.
package fifo_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} cons_state_t;
  localparam int FIFO_DATA_W = 8;
  localparam logic [7:0] SEQ_INIT = 8'h01;
endpackage

// File: rtl/fifo_skid_buf.sv
// fifo_skid_buf: 2-entry valid/ready buffer with registered output and visible occupancy.
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int DATA_W = FIFO_DATA_W
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              push_i,
  input  logic [DATA_W-1:0] data_i,
  output logic [DATA_W-1:0] m_data_o,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [1:0]        occ_o
);
  logic [DATA_W-1:0] out_q, out_d, skid_q, skid_d;
  logic              out_vld_q, out_vld_d, skid_vld_q, skid_vld_d, out_free;
  always_comb begin
    out_free   = !out_vld_q || m_ready_i;
    out_d      = out_free ? (skid_vld_q ? skid_q : push_i ? data_i : out_q) : out_q;
    out_vld_d  = out_free ? (skid_vld_q || push_i) : 1'b1;
    skid_vld_d = out_free ? (skid_vld_q && push_i) : (skid_vld_q || push_i);
    skid_d     = (push_i && (skid_vld_q || !out_free)) ? data_i : skid_q;
  end
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      out_vld_q  <= 1'b0;
      skid_q     <= '0;
      skid_vld_q <= 1'b0;
    end else begin
      out_q      <= out_d;
      out_vld_q  <= out_vld_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end
  assign m_data_o  = out_q;
  assign m_valid_o = out_vld_q;
  assign occ_o     = {1'b0, out_vld_q} + {1'b0, skid_vld_q};
  // Upstream credit logic must never push into a full, stalled buffer.
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rst_n)
    !(push_i && skid_vld_q && !m_ready_i));
endmodule

// File: rtl/fifo_seq_consumer.sv
// fifo_seq_consumer: drains a FIFO into a valid/ready stream and checks for an incrementing sequence.
module fifo_seq_consumer
  import fifo_pkg::*;
#(
  parameter int                DATA_W   = FIFO_DATA_W,
  parameter int                CNT_W    = 16,
  parameter logic [DATA_W-1:0] EXP_INIT = SEQ_INIT
) (
  input  logic              rd_clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic              clear,
  input  logic              empty,
  input  logic [DATA_W-1:0] dout,
  output logic              rd_en,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [CNT_W-1:0]  rx_count,
  output logic [CNT_W-1:0]  err_count,
  output logic              seq_err,
  output logic [DATA_W-1:0] last_bad
);
  cons_state_t       state_q, state_d;
  logic              rd_vld_q, seq_q, seq_d, mismatch, pop;
  logic [DATA_W-1:0] exp_q, exp_d, bad_q, bad_d;
  logic [CNT_W-1:0]  rx_q, rx_d, err_q, err_d;
  logic [1:0]        occ;
  logic [2:0]        credit;
  fifo_skid_buf #(.DATA_W(DATA_W)) u_buf (
    .rd_clk   (rd_clk),
    .rst_n    (rst_n),
    .push_i   (rd_vld_q),
    .data_i   (dout),
    .m_data_o (m_data),
    .m_valid_o(m_valid),
    .m_ready_i(m_ready),
    .occ_o    (occ)
  );
  // Credit counts buffered words plus the read in flight, minus the word leaving now.
  always_comb begin
    pop    = m_valid && m_ready;
    credit = {1'b0, occ} + {2'b0, rd_vld_q} - {2'b0, pop};
    rd_en  = (state_q == RUN) && !empty && (credit < 3'd2);
    state_d = state_q;
    case (state_q)
      IDLE:    if (enable) state_d = RUN;
      RUN:     if (!enable) state_d = DRAIN;
      default: if (enable) state_d = RUN;
               else if (!rd_vld_q && occ == 2'd0) state_d = IDLE;
    endcase
    mismatch = rd_vld_q && (dout != exp_q);
    rx_d  = clear ? '0 : (rd_vld_q && ~&rx_q) ? rx_q + 1'b1 : rx_q;
    err_d = clear ? '0 : (mismatch && ~&err_q) ? err_q + 1'b1 : err_q;
    seq_d = mismatch && !clear;
    bad_d = clear ? '0 : mismatch ? dout : bad_q;
    exp_d = clear ? EXP_INIT : rd_vld_q ? dout + 1'b1 : exp_q;
  end
  always_ff @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      rd_vld_q <= 1'b0;
      exp_q    <= EXP_INIT;
      rx_q     <= '0;
      err_q    <= '0;
      seq_q    <= 1'b0;
      bad_q    <= '0;
    end else begin
      state_q  <= state_d;
      rd_vld_q <= rd_en;
      exp_q    <= exp_d;
      rx_q     <= rx_d;
      err_q    <= err_d;
      seq_q    <= seq_d;
      bad_q    <= bad_d;
    end
  end
  assign rx_count  = rx_q;
  assign err_count = err_q;
  assign seq_err   = seq_q;
  assign last_bad  = bad_q;
endmodule

// File: tb/tb_fifo_seq_consumer.sv
// tb_fifo_seq_consumer: FIFO model plus sequence/stream reference model around fifo_seq_consumer.
module tb_fifo_seq_consumer;
  import fifo_pkg::*;
  localparam logic [7:0] EXP = 8'hFE;
  logic rd_clk = 0, rst_n = 0, enable = 0, clear = 0, empty = 1, m_ready = 0;
  logic rd_en, m_valid, seq_err;
  logic [7:0] dout = 0, m_data, last_bad;
  logic [15:0] rx_count, err_count;
  fifo_seq_consumer #(.DATA_W(8), .CNT_W(16), .EXP_INIT(EXP)) u_dut (
    .rd_clk(rd_clk), .rst_n(rst_n), .enable(enable), .clear(clear), .empty(empty),
    .dout(dout), .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .rx_count(rx_count), .err_count(err_count), .seq_err(seq_err), .last_bad(last_bad)
  );
  always #5 rd_clk = ~rd_clk;
  logic [7:0] fq[$], wq[$], sb[$];
  logic [7:0] cap_w = 0, m_exp = EXP, m_lb = 0, w = EXP, bad = 0;
  logic [15:0] m_rx = 0, m_err = 0;
  bit cap_v = 0, m_seq = 0, uflow = 0;
  int n_chk = 0, n_err = 0, n_mv = 0, n_rd = 0, n_seq = 0;
  // Reference: a standard-mode FIFO, plus what the consumer must report for each captured word.
  always @(posedge rd_clk or negedge rst_n) begin
    if (!rst_n) begin
      fq.delete(); sb.delete();
      cap_v = 0; m_seq = 0; m_rx = 0; m_err = 0; m_lb = 0; m_exp = EXP;
      empty <= 1'b1;
    end else begin
      m_seq = 0;
      if (cap_v) begin
        sb.push_back(cap_w);
        if (!clear) begin
          if (m_rx != 16'hFFFF) m_rx = m_rx + 1;
          if (cap_w != m_exp) begin
            m_seq = 1;
            if (m_err != 16'hFFFF) m_err = m_err + 1;
            m_lb = cap_w;
          end
          m_exp = cap_w + 8'd1;
        end
      end
      if (clear) begin m_rx = 0; m_err = 0; m_lb = 0; m_exp = EXP; end
      cap_v = rd_en;
      if (rd_en) begin
        if (fq.size() == 0) uflow = 1;
        else begin cap_w = fq.pop_front(); dout <= cap_w; end
      end
      while (wq.size() > 0) fq.push_back(wq.pop_front());
      empty <= (fq.size() == 0);
    end
  end
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask
  task automatic mon();
    if (m_valid) begin
      if (sb.size() == 0) chk("unexpected_m_valid", 32'(m_valid), 0);
      else begin
        chk("m_data", 32'(m_data), 32'(sb[0]));
        if (m_ready) begin void'(sb.pop_front()); n_mv++; end
      end
    end
    chk("rx_count", 32'(rx_count), 32'(m_rx));
    chk("err_count", 32'(err_count), 32'(m_err));
    chk("last_bad", 32'(last_bad), 32'(m_lb));
    chk("seq_err", 32'(seq_err), 32'(m_seq));
    chk("fifo_underflow", 32'(uflow), 0);
    if (rd_en) n_rd++;
    if (seq_err) n_seq++;
  endtask
  task automatic cyc();
    @(negedge rd_clk);
    mon();
    @(posedge rd_clk);
    #1;
  endtask
  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin wq.push_back(w); w = w + 8'd1; end
  endtask
  task automatic chk_zero(input string tag);
    chk({tag, "_rd_en"}, 32'(rd_en), 0);
    chk({tag, "_m_valid"}, 32'(m_valid), 0);
    chk({tag, "_seq_err"}, 32'(seq_err), 0);
    chk({tag, "_m_data"}, 32'(m_data), 0);
    chk({tag, "_last_bad"}, 32'(last_bad), 0);
    chk({tag, "_rx_count"}, 32'(rx_count), 0);
    chk({tag, "_err_count"}, 32'(err_count), 0);
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int k;
    repeat (2) @(posedge rd_clk);
    #1;
    chk_zero("reset");
    rst_n = 1;
    // In-order stream at full rate; starts at FE so FF->00 wrap is exercised.
    push_n(8); enable = 1; m_ready = 1;
    k = 0;
    while (!m_valid && k < 10) begin cyc(); k++; end
    chk("p1_first_valid", 32'(m_valid), 1);
    repeat (8) begin chk("p1_stream", 32'(m_valid), 1); cyc(); end
    cyc();
    chk("p1_rx", 32'(rx_count), 8);
    chk("p1_err", 32'(err_count), 0);
    chk("p1_rd_en_empty", 32'(rd_en), 0);
    // Backpressure: two reads at most, head word held.
    m_ready = 0; bad = w; push_n(8); n_rd = 0;
    repeat (12) cyc();
    chk("bp_reads", n_rd, 2);
    chk("bp_valid", 32'(m_valid), 1);
    chk("bp_hold", 32'(m_data), 32'(bad));
    m_ready = 1;
    repeat (14) cyc();
    chk("bp_rx", 32'(rx_count), 16);
    chk("bp_drained", sb.size(), 0);
    // Skip one value: exactly one error, then resync.
    push_n(2); w = w + 8'd1; bad = w; push_n(2); n_seq = 0;
    repeat (10) cyc();
    chk("err_pulses", n_seq, 1);
    chk("err_count1", 32'(err_count), 1);
    chk("err_last_bad", 32'(last_bad), 32'(bad));
    chk("err_rx", 32'(rx_count), 20);
    // Drop enable mid-stream.
    push_n(10);
    repeat (3) cyc();
    enable = 0;
    cyc();
    n_rd = 0;
    repeat (15) cyc();
    chk("drain_rd_en", n_rd, 0);
    chk("drain_m_valid", 32'(m_valid), 0);
    chk("drain_delivered", sb.size(), 0);
    chk("drain_idle", 32'(u_dut.state_q), 32'(IDLE));
    // Clear coincident with a captured word.
    enable = 1; push_n(4);
    k = 0;
    while (!cap_v && k < 20) begin cyc(); k++; end
    chk("clr_capture_seen", 32'(cap_v), 1);
    clear = 1;
    cyc();
    clear = 0;
    chk("clr_rx", 32'(rx_count), 0);
    chk("clr_err", 32'(err_count), 0);
    chk("clr_last_bad", 32'(last_bad), 0);
    chk("clr_forwarded", 32'(m_valid), 1);
    repeat (20) cyc();
    // Random enable/backpressure/clear with occasional sequence gaps.
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(19) == 0) enable = !enable;
      m_ready = $urandom_range(3) != 0;
      clear = $urandom_range(63) == 0;
      if ($urandom_range(1) == 1) begin
        if ($urandom_range(15) == 0) w = w + 8'd1;
        push_n(1);
      end
      cyc();
    end
    clear = 0; enable = 1; m_ready = 1;
    k = 0;
    while ((fq.size() != 0 || wq.size() != 0 || sb.size() != 0 || m_valid) && k < 3000) begin cyc(); k++; end
    chk("rand_drained", sb.size() + fq.size() + wq.size(), 0);
    // Asynchronous reset mid-burst.
    push_n(8);
    repeat (4) cyc();
    #2;
    rst_n = 0;
    #1;
    chk_zero("async_rst");
    repeat (2) cyc();
    rst_n = 1;
    chk("rst_rx", 32'(rx_count), 0);
    w = EXP; push_n(4);
    repeat (12) cyc();
    chk("rst_rx4", 32'(rx_count), 4);
    chk("rst_err0", 32'(err_count), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
